entropy_sampler: RTL and testbench
==================================

ENTROPY_SAMPLER -- requirements
Module: entropy_sampler

Interface
REQ-001 SHALL have parameter NUM_ROSC, default 32: number of ring-oscillator inputs, range 1..64.
REQ-002 SHALL have parameter SAMPLE_DIV, default 16: clk cycles between samples, range 2..65535.
REQ-003 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: sampling/collection enable.
REQ-006 SHALL have port rosc_in, input, NUM_ROSC: raw free-running oscillator outputs, asynchronous to clk.
REQ-007 SHALL have port rnd_ack, input, 1: consumer accepts rnd_data when high with rnd_valid high.
REQ-008 SHALL have port rnd_data, output, 32: collected entropy word.
REQ-009 SHALL have port rnd_valid, output, 1: rnd_data holds an unconsumed word.

Function
REQ-010 SHALL pass every rosc_in bit through a two-flop synchronizer; sample bit = XOR-reduce of synchronized bits; input-to-sample latency 2 cycles.
REQ-011 SHALL run 16-bit sample_ctr while enable=1, counting 0..SAMPLE_DIV-1, wrapping to 0; strobe when sample_ctr==SAMPLE_DIV-1.
REQ-012 SHALL implement FSM IDLE, COLLECT, FULL; IDLE->COLLECT when enable=1; any state->IDLE when enable=0.
REQ-013 In COLLECT, each accepted bit SHALL shift 32-bit collector left, new bit into LSB, and increment 6-bit bit_cnt.
REQ-014 On the 32nd accepted bit: if rnd_valid=0, or rnd_valid=1 with rnd_ack=1 same cycle, SHALL load rnd_data with full collector, set rnd_valid=1 next cycle, clear bit_cnt, remain COLLECT.
REQ-015 Otherwise on the 32nd bit SHALL go FULL: collector held, strobes discarded, sample_ctr keeps running.
REQ-016 In FULL, on rnd_ack=1 SHALL transfer collector to rnd_data, keep rnd_valid=1, clear bit_cnt, return to COLLECT next cycle.
REQ-017 rnd_ack=1 with rnd_valid=1 and no transfer SHALL clear rnd_valid next cycle; rnd_ack with rnd_valid=0 SHALL be ignored.
REQ-018 rnd_data SHALL be stable while rnd_valid=1 until the ack cycle.
REQ-019 enable=0 SHALL clear sample_ctr, bit_cnt and collector next cycle; partial word discarded; rnd_data/rnd_valid retained and handshake still honoured.

Reset
REQ-020 reset_n=0 SHALL asynchronously clear synchronizers, sample_ctr, bit_cnt, collector, rnd_data=32'h0, rnd_valid=0, state=IDLE.
REQ-021 Reset deassertion mid-word SHALL restart collection from bit 0; no partial word ever presented.

Configuration
REQ-022 Macro ENTROPY_SAMPLER_VON_NEUMANN_EN defined: strobed bits SHALL be paired; pair 01 -> accept 0, 10 -> accept 1, 00/11 -> discard; pair register cleared with enable=0, reset, and while FULL.
REQ-023 Macro undefined: every strobed bit SHALL be accepted directly; no pairing logic synthesized.

Structure
REQ-024 Shared package entropy_pkg SHALL hold WORD_WIDTH=32, state enum type (IDLE, COLLECT, FULL), sample_ctr width 16.
REQ-025 Sub-module entropy_sync2 (two-flop synchronizer, parameter WIDTH, clk/reset_n) SHALL be instantiated once with WIDTH=NUM_ROSC.

Verification
REQ-026 NUM_ROSC=2, SAMPLE_DIV=4, rosc_in=2'b01 constant, enable=1 -> rnd_valid rises after 32 strobes (~130 cycles), rnd_data=32'hFFFFFFFF.
REQ-027 Same, rosc_in=2'b11 -> rnd_data=32'h00000000; pulse rnd_ack one cycle -> rnd_valid low next cycle.
REQ-028 rnd_ack held low across two words -> first rnd_data unchanged, FSM in FULL, strobes discarded; ack -> second word loaded, rnd_valid stays 1.
REQ-029 enable dropped after 10 bits, reasserted -> next word requires full 32 new bits; reset_n pulse mid-word -> all outputs 0 immediately.
REQ-030 With ENTROPY_SAMPLER_VON_NEUMANN_EN, sample stream alternating 0,1 -> 64 strobes per word, rnd_data=32'h00000000; constant stream -> rnd_valid never asserts.

Source files
------------

// File: rtl/entropy_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : entropy_pkg                                            |
// | Shared widths and FSM state type for the entropy sampler.        |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package entropy_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int CTR_WIDTH  = 16;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/entropy_sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : entropy_sync2                                          |
// | Two-flop synchronizer bank for asynchronous oscillator inputs.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module entropy_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/entropy_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : entropy_sampler                                        |
// | Samples XOR of synchronized ring oscillators every SAMPLE_DIV    |
// | clocks, packs accepted bits into 32-bit words with a valid/ack   |
// | handshake. Optional Von Neumann debiasing when the macro         |
// | ENTROPY_SAMPLER_VON_NEUMANN_EN is defined.                       |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module entropy_sampler
  import entropy_pkg::*;
#(
  parameter int NUM_ROSC   = 32,
  parameter int SAMPLE_DIV = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_ROSC-1:0]   rosc_in,
  input  logic                  rnd_ack,
  output logic [WORD_WIDTH-1:0] rnd_data,
  output logic                  rnd_valid
);

  localparam logic [CTR_WIDTH-1:0] DIV_LAST = CTR_WIDTH'(SAMPLE_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(WORD_WIDTH - 1);

  logic [NUM_ROSC-1:0]   rosc_sync;
  logic                  sample_bit;
  logic [CTR_WIDTH-1:0]  sample_ctr;
  logic                  strobe;
  logic                  accept_valid;
  logic                  accept_bit;
  logic                  ack_taken;
  logic [WORD_WIDTH-1:0] shifted;

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] collector, collector_next;
  logic [CNT_WIDTH-1:0]  bit_cnt, bit_cnt_next;
  logic [WORD_WIDTH-1:0] data_next;
  logic                  valid_next;

  entropy_sync2 #(
    .WIDTH (NUM_ROSC)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rosc_in),
    .q       (rosc_sync)
  );

  assign sample_bit = ^rosc_sync;
  assign strobe     = enable && (sample_ctr == DIV_LAST);
  assign ack_taken  = rnd_ack && rnd_valid;

  // Free-running sample divider, held at zero while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  sample_ctr <= '0;
    else if (!enable)              sample_ctr <= '0;
    else if (sample_ctr == DIV_LAST) sample_ctr <= '0;
    else                           sample_ctr <= sample_ctr + CTR_WIDTH'(1);
  end

`ifdef ENTROPY_SAMPLER_VON_NEUMANN_EN
  logic pair_have;
  logic pair_bit;

  // Holds the first bit of a pair; dropped whenever collection is not active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pair_have <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (!enable || state != COLLECT) begin
      pair_have <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (strobe) begin
      pair_have <= !pair_have;
      if (!pair_have) pair_bit <= sample_bit;
    end
  end

  // 01 yields 0 and 10 yields 1, i.e. the first bit of an unequal pair.
  assign accept_valid = strobe && (state == COLLECT) && pair_have && (pair_bit != sample_bit);
  assign accept_bit   = pair_bit;
`else
  assign accept_valid = strobe && (state == COLLECT);
  assign accept_bit   = sample_bit;
`endif

  assign shifted = {collector[WORD_WIDTH-2:0], accept_bit};

  // Next-state, collector and output-word logic.
  always_comb begin
    state_next     = state;
    collector_next = collector;
    bit_cnt_next   = bit_cnt;
    data_next      = rnd_data;
    valid_next     = rnd_valid;
    if (!enable) begin
      // Partial word is discarded; the held output word keeps its handshake.
      state_next     = IDLE;
      collector_next = '0;
      bit_cnt_next   = '0;
      if (ack_taken) valid_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_next = COLLECT;
          if (ack_taken) valid_next = 1'b0;
        end
        COLLECT: begin
          if (ack_taken) valid_next = 1'b0;
          if (accept_valid) begin
            collector_next = shifted;
            if (bit_cnt == BIT_LAST) begin
              if (!rnd_valid || rnd_ack) begin
                data_next    = shifted;
                valid_next   = 1'b1;
                bit_cnt_next = '0;
              end else begin
                state_next   = FULL;
                bit_cnt_next = bit_cnt + CNT_WIDTH'(1);
              end
            end else begin
              bit_cnt_next = bit_cnt + CNT_WIDTH'(1);
            end
          end
        end
        FULL: begin
          // A completed word waits here; strobes are ignored until drained.
          if (ack_taken || !rnd_valid) begin
            data_next    = collector;
            valid_next   = 1'b1;
            bit_cnt_next = '0;
            state_next   = COLLECT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      collector <= '0;
      bit_cnt   <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
    end else begin
      state     <= state_next;
      collector <= collector_next;
      bit_cnt   <= bit_cnt_next;
      rnd_data  <= data_next;
      rnd_valid <= valid_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_entropy_sampler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_entropy_sampler                                     |
// | Self-checking bench for entropy_sampler (NUM_ROSC=2, DIV=4).     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_entropy_sampler;

  localparam int NR  = 2;
  localparam int DIV = 4;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable  = 1'b0;
  logic          rnd_ack = 1'b0;
  logic [NR-1:0] rosc_in = '0;
  logic [31:0]   rnd_data;
  logic          rnd_valid;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  rosc;
    logic [31:0] word;
  } vec_t;

  entropy_sampler #(
    .NUM_ROSC   (NR),
    .SAMPLE_DIV (DIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .rosc_in   (rosc_in),
    .rnd_ack   (rnd_ack),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!rnd_valid && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic ack_pulse();
    rnd_ack = 1'b1;
    tick(1);
    rnd_ack = 1'b0;
  endtask

  task automatic restart(input logic [1:0] r);
    enable  = 1'b0;
    rosc_in = r;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
  endtask

  // Every accepted handshake is matched against the next queued word.
  always @(negedge clk) begin
    if (reset_n && rnd_valid && rnd_ack) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: got %h want <none>", rnd_data);
      end else begin
        check("scoreboard", rnd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    int          n;
    logic [31:0] pat;

    vecs[0] = '{rosc: 2'b01, word: 32'hFFFF_FFFF};
    vecs[1] = '{rosc: 2'b10, word: 32'hFFFF_FFFF};
    vecs[2] = '{rosc: 2'b11, word: 32'h0000_0000};
    vecs[3] = '{rosc: 2'b00, word: 32'h0000_0000};
    pat = 32'hA5C3_0F96;

    tick(2);
    check("reset_valid", {31'b0, rnd_valid}, 32'd0);
    check("reset_data", rnd_data, 32'd0);
    reset_n = 1'b1;
    tick(2);

`ifndef ENTROPY_SAMPLER_VON_NEUMANN_EN
    // Constant oscillator patterns: one word each after 32 strobes.
    for (int i = 0; i < 4; i++) begin
      restart(vecs[i].rosc);
      exp_q.push_back(vecs[i].word);
      enable = 1'b1;
      wait_valid(300, n);
      check("vec_latency", 32'(n), 32'd128);
      check("vec_valid_up", {31'b0, rnd_valid}, 32'd1);
      ack_pulse();
      check("vec_valid_clr", {31'b0, rnd_valid}, 32'd0);
    end

    // Bit-by-bit word: checks shift order, MSB arrives first.
    restart(2'b00);
    exp_q.push_back(pat);
    enable = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      rosc_in = {1'b0, pat[i]};
      tick(4);
    end
    check("pat_valid", {31'b0, rnd_valid}, 32'd1);
    ack_pulse();
    check("pat_valid_clr", {31'b0, rnd_valid}, 32'd0);

    // Back-pressure: second word parks in FULL, later strobes are dropped.
    restart(2'b01);
    exp_q.push_back(32'hFFFF_FFFF);
    enable = 1'b1;
    wait_valid(300, n);
    check("bp_latency", 32'(n), 32'd128);
    rosc_in = 2'b11;
    tick(150);
    check("bp_hold_data", rnd_data, 32'hFFFF_FFFF);
    check("bp_hold_valid", {31'b0, rnd_valid}, 32'd1);
    rosc_in = 2'b01;
    tick(40);
    ack_pulse();
    check("bp_xfer_valid", {31'b0, rnd_valid}, 32'd1);
    check("bp_xfer_data", rnd_data, 32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
    ack_pulse();
    check("bp_final_clr", {31'b0, rnd_valid}, 32'd0);

    // Enable drop after 10 zero bits: next word needs 32 fresh ones.
    restart(2'b11);
    enable = 1'b1;
    tick(42);
    enable = 1'b0;
    tick(2);
    rosc_in = 2'b01;
    tick(3);
    exp_q.push_back(32'hFFFF_FFFF);
    enable = 1'b1;
    wait_valid(300, n);
    check("en_drop_latency", 32'(n), 32'd128);
    ack_pulse();

    // Asynchronous reset mid-word with a word pending.
    restart(2'b01);
    enable = 1'b1;
    wait_valid(300, n);
    tick(20);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", {31'b0, rnd_valid}, 32'd0);
    check("rst_async_data", rnd_data, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_valid(300, n);
    check("rst_restart_latency", 32'(n), 32'd128);
    exp_q.push_back(32'hFFFF_FFFF);
    ack_pulse();
    enable = 1'b0;
`else
    // Alternating 0,1 stream: every pair yields a 0, 64 strobes per word.
    restart(2'b00);
    exp_q.push_back(32'h0000_0000);
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rosc_in = {1'b0, i[0]};
      tick(4);
      if (i == 62) check("vn_alt_not_early", {31'b0, rnd_valid}, 32'd0);
    end
    check("vn_alt_valid", {31'b0, rnd_valid}, 32'd1);
    ack_pulse();
    check("vn_alt_clr", {31'b0, rnd_valid}, 32'd0);

    // Pairs b,~b encode pattern bit b.
    restart(2'b00);
    exp_q.push_back(pat);
    enable = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      rosc_in = {1'b0, pat[i]};
      tick(4);
      rosc_in = {1'b0, ~pat[i]};
      tick(4);
    end
    check("vn_pat_valid", {31'b0, rnd_valid}, 32'd1);
    ack_pulse();
    check("vn_pat_clr", {31'b0, rnd_valid}, 32'd0);

    // Constant streams never produce a word.
    for (int i = 0; i < 2; i++) begin
      restart(vecs[i * 2].rosc);
      enable = 1'b1;
      wait_valid(400, n);
      check("vn_const_valid", {31'b0, rnd_valid}, 32'd0);
      check("vn_const_data", rnd_data, 32'd0);
    end
    enable = 1'b0;
`endif

    tick(4);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d want 0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
